// File: rtl/botoes_condicionador_if.sv
// Signal bundle between the game UC / button pins and the button conditioner.
interface botoes_condicionador_if;
   logic [7:0] botoes_raw;
   logic       habilita;
   logic       limpar;
   logic [7:0] pulsos;
   logic       pendente;
   logic [7:0] db_estavel;

   modport master (
      output botoes_raw, habilita, limpar,
      input  pulsos, pendente, db_estavel
   );

   modport slave (
      input  botoes_raw, habilita, limpar,
      output pulsos, pendente, db_estavel
   );
endinterface

// File: rtl/botoes_condicionador.sv
// Push-button conditioner: sync, debounce, press edge, pending queue and one-hot issue.
// Defining CONTADOR_JOGADAS_EN adds the contagem_jogadas move counter output.
module botoes_condicionador #(
   parameter int DEBOUNCE_CYCLES   = 50000,
   parameter bit BOTAO_ATIVO_BAIXO = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   botoes_condicionador_if.slave bus
`ifdef CONTADOR_JOGADAS_EN
   ,
   output logic [7:0]            contagem_jogadas
`endif
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] LIMITE = CW'(DEBOUNCE_CYCLES - 1);

   logic [7:0]    nivel;
   logic [7:0]    sync1;
   logic [7:0]    sync2;
   logic [7:0]    estavel;
   logic [7:0]    estavel_d;
   logic [7:0]    pend;
   logic [7:0]    pulsos_q;
   logic [7:0]    press;
   logic [7:0]    menor;
   logic [7:0]    servido;
   logic [CW-1:0] cnt [8];

   assign nivel = BOTAO_ATIVO_BAIXO ? ~bus.botoes_raw : bus.botoes_raw;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= nivel;
         sync2 <= sync1;
      end
   end

   // The stable level only moves after sync has disagreed for DEBOUNCE_CYCLES consecutive edges.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         estavel   <= '0;
         estavel_d <= '0;
         for (int i = 0; i < 8; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         estavel_d <= estavel;
         for (int i = 0; i < 8; i++) begin
            if (sync2[i] == estavel[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == LIMITE) begin
               estavel[i] <= sync2[i];
               cnt[i]     <= '0;
            end else begin
               cnt[i] <= cnt[i] + CW'(1);
            end
         end
      end
   end

   assign press   = estavel & ~estavel_d;
   // Two's-complement trick isolates the lowest pending index.
   assign menor   = pend & (~pend + 8'd1);
   assign servido = bus.habilita ? menor : 8'd0;

   // Clearing beats setting; a fresh press of the bit being served keeps it pending.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pend     <= '0;
         pulsos_q <= '0;
      end else begin
         pulsos_q <= servido;
         if (bus.limpar || !bus.habilita) begin
            pend <= '0;
         end else begin
            pend <= (pend & ~servido) | press;
         end
      end
   end

   assign bus.pulsos     = pulsos_q;
   assign bus.pendente   = |pend;
   assign bus.db_estavel = estavel;

`ifdef CONTADOR_JOGADAS_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         contagem_jogadas <= '0;
      end else if (bus.limpar) begin
         contagem_jogadas <= '0;
      end else if (pulsos_q != 8'd0) begin
         contagem_jogadas <= contagem_jogadas + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_botoes_condicionador.sv
// Bench for botoes_condicionador: directed vector table, hand sequences and a random run
// against a behavioural model (DEBOUNCE_CYCLES=4, active-low pins).
module tb_botoes_condicionador;
   localparam int D = 4;

   typedef struct {
      logic [7:0] raw;
      logic       hab;
      logic       lim;
      int         n;
      logic [7:0] puls;
      logic       pend;
      logic [7:0] db;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   int   vectors;
   int   miscompares;
   vec_t tbl [$];

   logic [7:0] m_s1, m_s2, m_est, m_est_d, m_pend, m_puls;
   logic [7:0] hist [$];

   botoes_condicionador_if bus ();

`ifdef CONTADOR_JOGADAS_EN
   logic [7:0] contagem_jogadas;
`endif

   botoes_condicionador #(
      .DEBOUNCE_CYCLES   (D),
      .BOTAO_ATIVO_BAIXO (1'b1)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .bus              (bus)
`ifdef CONTADOR_JOGADAS_EN
      ,
      .contagem_jogadas (contagem_jogadas)
`endif
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(logic [7:0] raw, logic hab, logic lim, int n,
                               logic [7:0] puls, logic pend, logic [7:0] db);
      vec_t v;
      v.raw = raw; v.hab = hab; v.lim = lim; v.n = n;
      v.puls = puls; v.pend = pend; v.db = db;
      return v;
   endfunction

   function automatic logic [31:0] dut_outs();
      return {15'd0, bus.pulsos, bus.pendente, bus.db_estavel};
   endfunction

   task automatic check_output(string name, logic [31:0] act, logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic apply_stimulus(logic [7:0] raw, logic hab, logic lim);
      bus.botoes_raw = raw;
      bus.habilita   = hab;
      bus.limpar     = lim;
   endtask

   task automatic model_reset();
      m_s1 = '0; m_s2 = '0; m_est = '0; m_est_d = '0; m_pend = '0; m_puls = '0;
      hist.delete();
      for (int k = 0; k < D; k++) hist.push_back(8'h00);
   endtask

   // A stable level flips once its synchronized copy has disagreed on each of the last D edges.
   task automatic model_step();
      logic [7:0] norm, serve, press;
      norm  = ~bus.botoes_raw;
      serve = 8'h00;
      if (bus.habilita) begin
         for (int i = 0; i < 8; i++) begin
            if (m_pend[i] && serve == 8'h00) serve[i] = 1'b1;
         end
      end
      press   = m_est & ~m_est_d;
      m_est_d = m_est;
      m_puls  = serve;
      if (bus.limpar || !bus.habilita) m_pend = 8'h00;
      else m_pend = (m_pend & ~serve) | press;
      hist.push_back(m_s2);
      if (hist.size() > D) void'(hist.pop_front());
      for (int i = 0; i < 8; i++) begin
         bit todos;
         todos = 1'b1;
         for (int k = 0; k < hist.size(); k++) begin
            if (hist[k][i] == m_est[i]) todos = 1'b0;
         end
         if (todos) m_est[i] = ~m_est[i];
      end
      m_s2 = m_s1;
      m_s1 = norm;
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      check_output("model", dut_outs(), {15'd0, m_puls, (m_pend != 8'h00), m_est});
      check_output("onehot", {31'd0, ($countones(bus.pulsos) <= 1)}, 32'd1);
   endtask

   task automatic apply_reset();
      rst = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
   endtask

   initial begin
      logic [7:0] lvl;
      logic       hab;
      int         hold [8];

      vectors = 0;
      miscompares = 0;
      rst = 1'b1;
      apply_stimulus(8'hFF, 1'b1, 1'b0);

      // Single held press, then a 3-cycle glitch, a clear, and a triple simultaneous press.
      tbl.push_back(mk(8'hFB, 1, 0,   5, 8'h00, 0, 8'h00));
      tbl.push_back(mk(8'hFB, 1, 0,   1, 8'h00, 0, 8'h04));
      tbl.push_back(mk(8'hFB, 1, 0,   1, 8'h00, 1, 8'h04));
      tbl.push_back(mk(8'hFB, 1, 0,   1, 8'h04, 0, 8'h04));
      tbl.push_back(mk(8'hFB, 1, 0, 100, 8'h00, 0, 8'h04));
      tbl.push_back(mk(8'hFF, 1, 0,   5, 8'h00, 0, 8'h04));
      tbl.push_back(mk(8'hFF, 1, 0,   5, 8'h00, 0, 8'h00));
      tbl.push_back(mk(8'hDF, 1, 0,   3, 8'h00, 0, 8'h00));
      tbl.push_back(mk(8'hFF, 1, 0,  12, 8'h00, 0, 8'h00));
      tbl.push_back(mk(8'hFF, 1, 1,   1, 8'h00, 0, 8'h00));
      tbl.push_back(mk(8'h5E, 1, 0,   5, 8'h00, 0, 8'h00));
      tbl.push_back(mk(8'h5E, 1, 0,   1, 8'h00, 0, 8'hA1));
      tbl.push_back(mk(8'h5E, 1, 0,   1, 8'h00, 1, 8'hA1));
      tbl.push_back(mk(8'h5E, 1, 0,   1, 8'h01, 1, 8'hA1));
      tbl.push_back(mk(8'h5E, 1, 0,   1, 8'h20, 1, 8'hA1));
      tbl.push_back(mk(8'h5E, 1, 0,   1, 8'h80, 0, 8'hA1));
      tbl.push_back(mk(8'h5E, 1, 0,   5, 8'h00, 0, 8'hA1));
      tbl.push_back(mk(8'hFF, 1, 0,   5, 8'h00, 0, 8'hA1));
      tbl.push_back(mk(8'hFF, 1, 0,   5, 8'h00, 0, 8'h00));

      #1 rst = 1'b0;
      model_reset();
      #1 check_output("reset", dut_outs(), 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b1;

      for (int r = 0; r < tbl.size(); r++) begin
         apply_stimulus(tbl[r].raw, tbl[r].hab, tbl[r].lim);
         for (int c = 0; c < tbl[r].n; c++) begin
            tick();
            check_output($sformatf("table%0d", r), dut_outs(),
                         {15'd0, tbl[r].puls, tbl[r].pend, tbl[r].db});
         end
      end
`ifdef CONTADOR_JOGADAS_EN
      check_output("count_t3", {24'd0, contagem_jogadas}, 32'd3);
`endif

      // Press of button 3 while disabled is dropped; enabling while held must not revive it.
      apply_stimulus(8'hF7, 1'b0, 1'b0);
      repeat (10) tick();
      check_output("t4_db", {24'd0, bus.db_estavel}, 32'h08);
      apply_stimulus(8'hF7, 1'b1, 1'b0);
      for (int c = 0; c < 10; c++) begin
         tick();
         check_output("t4_held", {24'd0, bus.pulsos}, 32'h00);
      end
      apply_stimulus(8'hFF, 1'b1, 1'b0);
      repeat (10) tick();
      apply_stimulus(8'hF7, 1'b1, 1'b0);
      for (int c = 1; c <= 12; c++) begin
         tick();
         check_output("t4_repress", {24'd0, bus.pulsos}, (c == 8) ? 32'h08 : 32'h00);
      end
      apply_stimulus(8'hFF, 1'b1, 1'b0);
      repeat (10) tick();

      // limpar on the edge that launches the first of three queued pulses.
      apply_stimulus(8'hE9, 1'b1, 1'b0);
      repeat (7) tick();
      check_output("t5_queued", {31'd0, bus.pendente}, 32'd1);
      apply_stimulus(8'hE9, 1'b1, 1'b1);
      tick();
      check_output("t5_first", {23'd0, bus.pulsos, bus.pendente}, {23'd0, 8'h02, 1'b0});
      apply_stimulus(8'hE9, 1'b1, 1'b0);
      for (int c = 0; c < 6; c++) begin
         tick();
         check_output("t5_after", {23'd0, bus.pulsos, bus.pendente}, 32'd0);
      end
      apply_stimulus(8'hFF, 1'b1, 1'b0);
      repeat (10) tick();

      // Reset with pend=0x11 and button 6 mid-debounce; held buttons are re-seen as presses.
      apply_stimulus(8'hEE, 1'b1, 1'b0);
      repeat (2) tick();
      apply_stimulus(8'hAE, 1'b1, 1'b0);
      repeat (5) tick();
      check_output("t6_pre", {23'd0, bus.pendente, bus.db_estavel}, {23'd0, 1'b1, 8'h11});
      #2 rst = 1'b0;
      #1 check_output("t6_async", dut_outs(), 32'd0);
`ifdef CONTADOR_JOGADAS_EN
      check_output("t6_count", {24'd0, contagem_jogadas}, 32'd0);
`endif
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         tick();
         check_output("t6_after", {24'd0, bus.pulsos},
                      (c == 8) ? 32'h01 : (c == 9) ? 32'h10 : (c == 10) ? 32'h40 : 32'h00);
      end
      apply_stimulus(8'hFF, 1'b1, 1'b0);
      repeat (10) tick();

      // Random button activity mixing long holds with short glitches, enable drops and clears.
      lvl = 8'h00;
      hab = 1'b1;
      for (int i = 0; i < 8; i++) hold[i] = $urandom_range(1, 20);
      for (int c = 0; c < 1500; c++) begin
         for (int i = 0; i < 8; i++) begin
            if (hold[i] == 0) begin
               lvl[i]  = ($urandom_range(0, 1) == 1);
               hold[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(5, 25);
            end else begin
               hold[i]--;
            end
         end
         if (hab) hab = ($urandom_range(0, 59) != 0);
         else hab = ($urandom_range(0, 9) == 0);
         apply_stimulus(~lvl, hab, ($urandom_range(0, 29) == 0));
         if (c == 750) apply_reset();
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/botoes_condicionador.md
Name: botoes_condicionador

Overview:
Conditions the 8 raw push-button inputs of the LED-matrix puzzle before they reach the matrix controller's `botoes` bus. Per button it synchronizes, debounces and detects the press edge, then queues the press. Queued presses are issued as single-cycle, strictly one-hot pulses, so each physical press toggles the matrix exactly once. The block sits directly upstream of the matrix controller; the game UC gates it with `habilita`/`limpar`.

Parameters:
DEBOUNCE_CYCLES, 50000, consecutive cycles a synchronized level must differ from the stable level before the stable level is updated (≥2)
BOTAO_ATIVO_BAIXO, 1, 1 = raw pins read 0 when pressed (inverted at input); 0 = active-high pins

Ports:
clk  input  1  main FPGA clock
rst  input  1  asynchronous, active-low reset
botoes_raw  input  8  raw button pins, asynchronous to clk
habilita  input  1  UC permits moves; 0 discards new presses and pending presses
limpar  input  1  synchronous clear of the pending queue
pulsos  output  8  one-hot, single-cycle press pulses to matrix controller `botoes`
pendente  output  1  1 while any press is queued
db_estavel  output  8  debounced stable level per button (1 = pressed)

Behaviour:
- Reset (`rst`=0, async): sync FFs, stable levels, edge-history regs, counters and pending bits all cleared. Outputs `pulsos`=0, `pendente`=0, `db_estavel`=0.
- Input stage: polarity is normalized first; if BOTAO_ATIVO_BAIXO=1, each pin is inverted. The result then passes through a 2-FF synchronizer per bit.
- Debounce, per button:
  - Counter width is $clog2(DEBOUNCE_CYCLES+1).
  - When sync == estavel, the counter is cleared to 0.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1 while still differing, estavel takes the sync value and the counter clears.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles therefore never changes estavel.
- Edge detect: estavel_d is estavel delayed by one cycle. A press is estavel & ~estavel_d, detected on the rising edge of estavel only. Release edges are ignored.
- Pending register pend[7:0]:
  - A press sets pend[i] if habilita=1. If habilita=0 the press is dropped.
  - limpar=1 or habilita=0 clears all pend bits; this takes priority over a set in the same cycle.
  - If a set and the serve-clear of the same bit land in one cycle, the set wins and the bit stays pending.
- Issue stage:
  - Each cycle, if habilita=1 and pend≠0, the lowest set index i is selected. Next cycle `pulsos` = one-hot(i) and pend[i] clears.
  - Otherwise `pulsos`=0 next cycle.
  - Pulses may be back-to-back on consecutive cycles. `pulsos` never has more than 1 bit set.
- `pendente` = |pend (registered-state derived, no combinational path from inputs).
- Latency, clean press: raw asserted before edge 0 gives sync high at edge 2 and estavel high at edge 2+DEBOUNCE_CYCLES. pend is set at the next edge and `pulsos` is high for exactly one cycle after edge 4+DEBOUNCE_CYCLES.
- Holding a button produces exactly one pulse. The release and a re-press, each debounced, are needed for the next pulse.
- Simultaneous presses are served in ascending index order, one per cycle.
- Reset mid-debounce or mid-queue: everything is lost. After reset, a button that is still held is seen as a new press once debounced.

Optional Feature:
Macro CONTADOR_JOGADAS_EN.
- Defined: adds output `contagem_jogadas` [7:0].
  - Increments (wraps 255→0) on every cycle `pulsos`≠0.
  - Cleared by rst and by limpar.
- Not defined: the port and counter are absent; all other behaviour is identical.

Test Plan:
All tests use DEBOUNCE_CYCLES=4 and BOTAO_ATIVO_BAIXO=1.
1. Drive botoes_raw[2]=0 from edge 0 and hold, habilita=1 -> `pulsos`=8'b00000100 for exactly one cycle after edge 8, then 0 for 100 held cycles; db_estavel[2]=1.
2. Pulse botoes_raw[5] low for 3 cycles, then high -> `pulsos` stays 0, db_estavel stays 0, pendente stays 0.
3. Press buttons 0, 5 and 7 on the same edge -> `pulsos` = 8'h01, 8'h20, 8'h80 on three consecutive cycles; pendente falls after the last.
4. habilita=0 during a clean press of button 3, then habilita=1 while still held -> no pulse; release and re-press -> one 8'h08 pulse.
5. Queue 3 simultaneous presses, assert limpar on the cycle the first pulse issues -> only the first pulse appears; pend=0 after.
6. Assert rst=0 mid-debounce and with pend=8'h11 -> all outputs 0 immediately (async). With the button still held after release of rst, one pulse after 4+DEBOUNCE_CYCLES edges. With CONTADOR_JOGADAS_EN, verify the count=3 after test 3 and 0 after reset.
